// File: rtl/ble_link_deframer.sv
// BLE receive bit-level front end: access-address correlation, dewhitening, LSB-first byte
// assembly with section tags, and CRC-24 verification of the PDU.
module ble_link_deframer #(
  parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
  parameter int unsigned AA_ERR_TOL  = 0,
  parameter logic [23:0] CRC_INIT    = 24'h555555,
  parameter int unsigned MAX_LEN     = 37
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_in,
  input  logic       bit_valid,
  input  logic [5:0] channel_idx,
  input  logic       whiten_en,
  input  logic       abort,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic [7:0] packet_state,
  output logic       pkt_start,
  output logic       pkt_done,
  output logic       crc_ok,
  output logic       len_error
);

  typedef enum logic [1:0] {StSearch, StHeader, StPayload, StCrc} state_e;

  state_e      state_q, state_d;
  logic [31:0] sr_q, sr_d;
  logic [23:0] c_q, c_d;
  logic [6:0]  w_q, w_d;
  logic [7:0]  byte_sr_q, byte_sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  len_q, len_d;
  logic        crc_err_q, crc_err_d;
  logic [7:0]  data_out_q, data_out_d;
  logic        data_valid_q, data_valid_d;
  logic [7:0]  packet_state_q, packet_state_d;
  logic        pkt_start_q, pkt_start_d;
  logic        pkt_done_q, pkt_done_d;
  logic        crc_ok_q, crc_ok_d;
  logic        len_error_q, len_error_d;

  logic [31:0] sr_next, aa_diff;
  logic [5:0]  aa_mism;
  logic        aa_match;
  logic        wb, d, fb, crc_bit_bad, byte_end;
  logic [6:0]  w_next;
  logic [23:0] c_next;
  logic [7:0]  byte_next;

  always_comb begin
    sr_next = {bit_in, sr_q[31:1]};
    aa_diff = sr_next ^ ACCESS_ADDR;
    aa_mism = '0;
    for (int i = 0; i < 32; i++) begin
      aa_mism = aa_mism + {5'd0, aa_diff[i]};
    end
    aa_match = (32'(aa_mism) <= AA_ERR_TOL);
  end

  always_comb begin
    wb          = w_q[6];
    d           = bit_in ^ (wb & whiten_en);
    w_next      = {w_q[5:4], w_q[3] ^ wb, w_q[2:0], wb};
    fb          = c_q[23] ^ d;
    c_next      = {c_q[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
    crc_bit_bad = (d != c_q[23]);
    byte_next   = {d, byte_sr_q[7:1]};
    byte_end    = (bit_cnt_q == 3'd7);
  end

  always_comb begin
    state_d        = state_q;
    sr_d           = sr_q;
    c_d            = c_q;
    w_d            = w_q;
    byte_sr_d      = byte_sr_q;
    bit_cnt_d      = bit_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    len_d          = len_q;
    crc_err_d      = crc_err_q;
    data_out_d     = data_out_q;
    data_valid_d   = 1'b0;
    packet_state_d = packet_state_q;
    pkt_start_d    = 1'b0;
    pkt_done_d     = 1'b0;
    crc_ok_d       = crc_ok_q;
    len_error_d    = 1'b0;

    // Idle tag: this also drops the tag one cycle after the strobe that ended a packet.
    if (state_q == StSearch) packet_state_d = 8'h00;

    if (abort) begin
      state_d        = StSearch;
      sr_d           = '0;
      packet_state_d = 8'h00;
    end else if (bit_valid) begin
      unique case (state_q)
        StSearch: begin
          sr_d = sr_next;
          if (aa_match) begin
            state_d     = StHeader;
            pkt_start_d = 1'b1;
            crc_ok_d    = 1'b0;
            crc_err_d   = 1'b0;
            bit_cnt_d   = '0;
            byte_cnt_d  = '0;
            c_d         = CRC_INIT;
            w_d         = {channel_idx[0], channel_idx[1], channel_idx[2], channel_idx[3],
                           channel_idx[4], channel_idx[5], 1'b1};
          end
        end
        StHeader, StPayload, StCrc: begin
          w_d       = w_next;
          byte_sr_d = byte_next;
          bit_cnt_d = bit_cnt_q + 3'd1;
          // The CRC register is consumed MSB-first while the received CRC is checked.
          if (state_q == StCrc) begin
            c_d = {c_q[22:0], 1'b0};
            if (crc_bit_bad) crc_err_d = 1'b1;
          end else begin
            c_d = c_next;
          end
          if (byte_end) begin
            data_out_d   = byte_next;
            data_valid_d = 1'b1;
            byte_cnt_d   = byte_cnt_q + 8'd1;
            unique case (state_q)
              StHeader: begin
                packet_state_d = 8'h01;
                if (byte_cnt_q == 8'd1) begin
                  byte_cnt_d = '0;
                  len_d      = byte_next;
                  if (32'(byte_next) > MAX_LEN) begin
                    len_error_d = 1'b1;
                    state_d     = StSearch;
                    sr_d        = '0;
                  end else if (byte_next == 8'd0) begin
                    state_d = StCrc;
                  end else begin
                    state_d = StPayload;
                  end
                end
              end
              StPayload: begin
                packet_state_d = 8'h02;
                if (byte_cnt_q == len_q - 8'd1) begin
                  byte_cnt_d = '0;
                  state_d    = StCrc;
                end
              end
              StCrc: begin
                packet_state_d = 8'h03;
                if (byte_cnt_q == 8'd2) begin
                  pkt_done_d = 1'b1;
                  crc_ok_d   = ~(crc_err_q | crc_bit_bad);
                  state_d    = StSearch;
                  sr_d       = '0;
                end
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= StSearch;
      sr_q           <= '0;
      c_q            <= '0;
      w_q            <= '0;
      byte_sr_q      <= '0;
      bit_cnt_q      <= '0;
      byte_cnt_q     <= '0;
      len_q          <= '0;
      crc_err_q      <= 1'b0;
      data_out_q     <= '0;
      data_valid_q   <= 1'b0;
      packet_state_q <= '0;
      pkt_start_q    <= 1'b0;
      pkt_done_q     <= 1'b0;
      crc_ok_q       <= 1'b0;
      len_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      sr_q           <= sr_d;
      c_q            <= c_d;
      w_q            <= w_d;
      byte_sr_q      <= byte_sr_d;
      bit_cnt_q      <= bit_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      len_q          <= len_d;
      crc_err_q      <= crc_err_d;
      data_out_q     <= data_out_d;
      data_valid_q   <= data_valid_d;
      packet_state_q <= packet_state_d;
      pkt_start_q    <= pkt_start_d;
      pkt_done_q     <= pkt_done_d;
      crc_ok_q       <= crc_ok_d;
      len_error_q    <= len_error_d;
    end
  end

  assign data_out     = data_out_q;
  assign data_valid   = data_valid_q;
  assign packet_state = packet_state_q;
  assign pkt_start    = pkt_start_q;
  assign pkt_done     = pkt_done_q;
  assign crc_ok       = crc_ok_q;
  assign len_error    = len_error_q;

endmodule

// File: doc/ble_link_deframer.md
# ble_link_deframer

Bit-level receive front end of the BLE packet sniffer. It sits between the GFSK demodulator's sliced-bit output and the byte-oriented protocol decoder. It correlates the incoming bit stream against the access address, dewhitens the bits, and assembles them LSB-first into bytes. It then emits each byte with a section tag (header / payload / CRC) and a CRC-24 verdict for the whole PDU.

## Interface
- `ACCESS_ADDR`, default 32'h8E89BED6: access address to correlate; air order is bit 0 first.
- `AA_ERR_TOL`, default 0: maximum bit mismatches accepted on an access-address match (0..4).
- `CRC_INIT`, default 24'h555555: CRC-24 preset.
- `MAX_LEN`, default 37: largest legal PDU length byte.

Ports:
- `clk`  in  1: sole clock.
- `rst`  in  1: reset; asynchronous, active-high.
- `bit_in`  in  1: demodulated bit.
- `bit_valid`  in  1: `bit_in` is sampled on cycles where this is high; gaps of any length are allowed.
- `channel_idx`  in  6: RF channel; sampled at the access-address match to seed the whitening.
- `whiten_en`  in  1: 1 = dewhiten; 0 = pass bits unchanged.
- `abort`  in  1: synchronous return to SEARCH (channel hop).
- `data_out`  out  8: assembled byte.
- `data_valid`  out  1: one-cycle strobe per byte.
- `packet_state`  out  8: section of the current byte: 8'h00 idle, 8'h01 header, 8'h02 payload, 8'h03 CRC.
- `pkt_start`  out  1: one-cycle pulse on access-address match.
- `pkt_done`  out  1: one-cycle pulse, coincident with the last CRC byte's `data_valid`.
- `crc_ok`  out  1: CRC verdict; valid from `pkt_done` and held until the next `pkt_start`.
- `len_error`  out  1: one-cycle pulse when the length byte exceeds `MAX_LEN`.

## Operation
**States:** SEARCH, HEADER, PAYLOAD, CRC. A bit is processed only on a cycle with `bit_valid` high.

**SEARCH**
- `sr` is a 32-bit shift register; new bits enter at the MSB: `sr <= {bit_in, sr[31:1]}`.
- Match condition: popcount(`sr_next` ^ `ACCESS_ADDR`) <= `AA_ERR_TOL`.
- On match:
  - Go to HEADER and pulse `pkt_start`.
  - Clear `crc_ok`, the bit counter and the byte counter.
  - Load the CRC register `c` <= `CRC_INIT`.
  - Load the whitening register `w[6:0]` <= {ch[0],ch[1],ch[2],ch[3],ch[4],ch[5],1'b1}.

**Dewhitening (per processed bit, outside SEARCH)**
- `wb` = `w[6]`.
- `d` = `bit_in` ^ (`wb` & `whiten_en`).
- `w` shifts left: new `w[0]` = `wb`, `w[4]` = `w[3]` ^ `wb`, all other bits take `w[k-1]`.
- `w` advances every processed bit, even when `whiten_en` = 0.

**CRC-24 (HEADER and PAYLOAD bits only)**
- `fb` = `c[23]` ^ `d`.
- `c` <= {`c[22:0]`, 1'b0} ^ (`fb` ? 24'h00065B : 0).
- In the CRC state, received bit i (i = 0..23) is compared to `c[23-i]` of the register frozen at CRC entry.
- Any mismatch gives `crc_ok` = 0.

**Byte assembly**
- `d` shifts into `byte_sr` LSB-first.
- On the 8th bit, register `data_out`, strobe `data_valid`, and set `packet_state` to the current section tag.

**Sequencing**
- HEADER: 2 bytes. Header byte 1 is the length L.
  - If L > `MAX_LEN`: pulse `len_error` with that byte's strobe, then go to SEARCH. No `pkt_done`.
  - If L = 0: go directly to CRC.
  - Otherwise go to PAYLOAD.
- PAYLOAD: L bytes (8-bit counter), then CRC.
- CRC: 3 bytes. On the 3rd byte, pulse `pkt_done`, drive `crc_ok`, and go to SEARCH.
- On every entry to SEARCH, clear `sr` to 0 so trailing bits cannot re-match immediately.

**Abort, reset and idle values**
- `abort` high: go to SEARCH next cycle and clear `sr`. It has priority over a simultaneous bit; no strobe or pulse is issued on that cycle.
- Reset, including mid-packet: state SEARCH, all registers 0.
  - Output reset values: `data_out` 8'h00, `data_valid` 0, `packet_state` 8'h00, `pkt_start` 0, `pkt_done` 0, `crc_ok` 0, `len_error` 0.
- `packet_state` returns to 8'h00 one cycle after the strobe that ends a packet or an error.

## Timing
- All outputs are registered.
- `pkt_start` is high on the cycle after the `bit_valid` cycle carrying the 32nd access-address bit.
- `data_valid` is high on the cycle after the `bit_valid` cycle carrying a byte's 8th bit.
- `data_out` and `packet_state` are stable while `data_valid` is high; `data_out` holds afterwards.
- The first header bit may arrive on the cycle immediately after the match bit, i.e. back-to-back `bit_valid` is supported.
- Throughput: one bit per clock.
- Minimum packet: 40 bits after the access address (L = 0).

## Test plan
1. **Clean advertising packet.** `whiten_en`=0; preamble 8'hAA, AA 8E89BED6, header 02 03, payload 11 22 33, correct CRC.
   - Expect `pkt_start`, then 8 strobes with `data_out` = 02,03,11,22,33,c0,c1,c2 and `packet_state` 1,1,2,2,2,3,3,3.
   - Expect `pkt_done` with `crc_ok`=1.
2. **CRC corruption.** Same packet as 1 with payload bit 5 flipped.
   - Expect identical strobe count, `pkt_done`=1, `crc_ok`=0.
3. **Length handling.**
   - L=0: expect 5 strobes, tags 1,1,3,3,3.
   - L=40 with `MAX_LEN`=37: expect `len_error` on the 2nd strobe, return to SEARCH, no `pkt_done`.
4. **Whitening.** `whiten_en`=1, `channel_idx`=37, packet whitened by the bench model.
   - Expect dewhitened bytes identical to test 1 and `crc_ok`=1.
   - Repeat with random `bit_valid` gaps of 0–5 cycles; same result.
5. **Correlation tolerance.** Access address with 1 bit flipped.
   - `AA_ERR_TOL`=0: no `pkt_start`.
   - `AA_ERR_TOL`=1: `pkt_start` asserted.
6. **Abort and reset.** Assert `abort` during payload byte 2, then assert `rst` mid-header of the next packet.
   - Expect no further strobes after each, all outputs at their reset values, and a subsequent clean packet decoded correctly.
